// File: rtl/dmem_access_ctrl.sv
// Data-memory requester: latches one load/store, holds the request until acked, stalls the pipeline meanwhile.
// Optional build macro DMEM_TIMEOUT_EN adds a BUSY wait counter that aborts an unacknowledged access after TIMEOUT cycles.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic w_access;
    logic w_illegal;
    logic w_timeout;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("dmem_access_ctrl: TIMEOUT must be in 1..255");
    end

    assign w_access  = memRead_i | memWrite_i;
    assign w_illegal = (addr_i[1:0] != 2'b00) || (addr_i[31:ADDR_W+2] != '0);

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    // Counter value is the number of unacked BUSY cycles already spent.
    assign w_timeout = (r_state == S_BUSY) && !mem_ack_i && (r_wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || r_state != S_BUSY) begin
            r_wait_cnt <= 8'd0;
        end else if (!mem_ack_i) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_access && !w_illegal) w_next_state = S_BUSY;
            S_BUSY:  if (mem_ack_i || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o   = 1'b0;
        mem_req_o = 1'b0;
        case (r_state)
            S_IDLE:  stall_o = w_access & ~w_illegal;
            S_BUSY: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Write priority: a simultaneous read+write is issued as a write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access && w_illegal) begin
                        err_o <= 1'b1;
                    end else if (w_access) begin
                        mem_we_o    <= memWrite_i;
                        mem_addr_o  <= addr_i[ADDR_W+1:2];
                        mem_wdata_o <= wdata_i;
                    end
                end
                S_BUSY: begin
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            rdata_o       <= mem_rdata_i;
                            rdata_valid_o <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        err_o <= 1'b1;
                        if (!mem_we_o) begin
                            rdata_o       <= 32'hDEADBEEF;
                            rdata_valid_o <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
